ldpe_flag_collector: RTL and testbench

- Clocked collector downstream of a bank of LDPE latches used as sticky asynchronous event flags.
- Synchronizes the latch Q outputs into clock C and presents a snapshot of set flags to a consumer over a valid/ready handshake.
- After the snapshot is accepted, it drives the latch bank's G/GE/D inputs to clear exactly the reported flags.
- Flags are not lost when a flag re-asserts during the clear.

---
 rtl/ldpe_flag_pkg.sv | 24 ++
 rtl/flag_sync_bit.sv | 31 +++
 rtl/ldpe_flag_collector.sv | 150 +++++++++++++++
 tb/tb_ldpe_flag_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldpe_flag_pkg.sv
// rtl/ldpe_flag_pkg.sv - shared types, constants and helpers for the LDPE flag collector
//
// Purpose: collector FSM state encoding, the largest supported flag width, and
// the function sizing the shared clear/settle/flush counter.
package ldpe_flag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam int MAX_WIDTH = 32;

  // The counter must hold the larger of the clear length and the settle
  // length (SYNC_STAGES+1), including that value itself.
  function automatic int cnt_width(input int clr_cycles, input int sync_stages);
    int m;
    m = (clr_cycles > sync_stages + 1) ? clr_cycles : sync_stages + 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/flag_sync_bit.sv
// rtl/flag_sync_bit.sv - N-stage single-bit synchronizer with reset value INIT
//
// Purpose: brings one asynchronous latch Q output into the collector clock.
// Ports:
//   c_i    clock, rising edge
//   clr_i  asynchronous active-high reset, loads every stage with INIT
//   d_i    asynchronous input bit
//   q_o    synchronized output (last stage)
module flag_sync_bit #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic c_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge c_i or posedge clr_i) begin
    if (clr_i) begin
      ff_q <= {STAGES{INIT}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/ldpe_flag_collector.sv
// rtl/ldpe_flag_collector.sv - snapshot-and-clear collector for a bank of LDPE sticky flags
//
// Purpose: synchronizes the latch Q outputs, hands a snapshot of the set flags
// to a consumer over valid/ready, then pulses the latch G with GE restricted to
// the reported flags and D=0 so only those flags are cleared.
// Ports:
//   C         clock, rising edge
//   CLR       asynchronous active-high reset
//   FLAG_Q    asynchronous latch Q outputs
//   SNAP      captured flag vector, stable while SNAP_VLD=1
//   SNAP_VLD  snapshot valid
//   SNAP_RDY  consumer ready; acceptance on SNAP_VLD & SNAP_RDY
//   LAT_G     latch gate, common to all latches
//   LAT_GE    per-latch gate enable, equal to the accepted snapshot
//   LAT_D     latch data, constant 0
//   BUSY      high whenever the FSM is not in IDLE
module ldpe_flag_collector
  import ldpe_flag_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   CLR_CYCLES  = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] FLAG_Q,
  output logic [WIDTH-1:0] SNAP,
  output logic             SNAP_VLD,
  input  logic             SNAP_RDY,
  output logic             LAT_G,
  output logic [WIDTH-1:0] LAT_GE,
  output logic [WIDTH-1:0] LAT_D,
  output logic             BUSY
);

  localparam int CNT_W = cnt_width(CLR_CYCLES, SYNC_STAGES);

  // With INIT=1 the synchronizers come out of reset full of ones; IDLE must
  // not treat them as flags until they have been flushed by real samples.
  localparam logic [CNT_W-1:0] FLUSH_RST = INIT ? CNT_W'(SYNC_STAGES) : '0;

  logic [WIDTH-1:0] flag_s;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             vld_q, vld_d;
  logic             g_q, g_d;
  logic [WIDTH-1:0] ge_q, ge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    flag_sync_bit #(
      .STAGES (SYNC_STAGES),
      .INIT   (INIT)
    ) u_sync (
      .c_i   (C),
      .clr_i (CLR),
      .d_i   (FLAG_Q[i]),
      .q_o   (flag_s[i])
    );
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      snap_q  <= {WIDTH{INIT}};
      vld_q   <= 1'b0;
      g_q     <= 1'b0;
      ge_q    <= '0;
      cnt_q   <= '0;
      flush_q <= FLUSH_RST;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      vld_q   <= vld_d;
      g_q     <= g_d;
      ge_q    <= ge_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    vld_d   = vld_q;
    g_d     = g_q;
    ge_d    = ge_q;
    cnt_d   = cnt_q;
    flush_d = (flush_q == '0) ? '0 : flush_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if ((flush_q == '0) && (|flag_s)) begin
          snap_d  = flag_s;
          vld_d   = 1'b1;
          state_d = REPORT;
        end
      end

      REPORT: begin
        if (SNAP_RDY) begin
          vld_d   = 1'b0;
          ge_d    = snap_q;
          g_d     = 1'b1;
          cnt_d   = CNT_W'(CLR_CYCLES);
          state_d = CLEAR;
        end
      end

      // G was raised on the accept edge, so expiring when the counter reads 1
      // gives exactly CLR_CYCLES cycles of G high. GE stays up one more cycle.
      CLEAR: begin
        if (cnt_q <= CNT_W'(1)) begin
          g_d     = 1'b0;
          cnt_d   = CNT_W'(SYNC_STAGES + 1);
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // flag_s is ignored here so ones still in flight through the
      // synchronizer from before the clear are not reported again.
      SETTLE: begin
        ge_d = '0;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign SNAP     = snap_q;
  assign SNAP_VLD = vld_q;
  assign LAT_G    = g_q;
  assign LAT_GE   = ge_q;
  assign LAT_D    = '0;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_ldpe_flag_collector.sv
// tb/tb_ldpe_flag_collector.sv - directed self-checking bench for ldpe_flag_collector
module tb_ldpe_flag_collector;

  logic       c = 1'b0;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] pre = 8'h00;
  logic [7:0] lq = 8'h00;
  logic [7:0] snap, ge, d;
  logic       vld, g, busy;

  logic [7:0] zero8 = 8'h00;
  logic [7:0] snap2, ge2, d2;
  logic       vld2, g2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 c = ~c;

  // LDPE bank: PRE dominates, otherwise transparent while G & GE.
  always @* begin
    for (int i = 0; i < 8; i++) begin
      if (pre[i]) lq[i] = 1'b1;
      else if (g && ge[i]) lq[i] = d[i];
    end
  end

  ldpe_flag_collector #(
    .WIDTH(8), .SYNC_STAGES(2), .CLR_CYCLES(2), .INIT(1'b0)
  ) dut (
    .C(c), .CLR(clr), .FLAG_Q(lq), .SNAP(snap), .SNAP_VLD(vld), .SNAP_RDY(rdy),
    .LAT_G(g), .LAT_GE(ge), .LAT_D(d), .BUSY(busy)
  );

  ldpe_flag_collector #(
    .WIDTH(8), .SYNC_STAGES(2), .CLR_CYCLES(2), .INIT(1'b1)
  ) dut_init (
    .C(c), .CLR(clr), .FLAG_Q(zero8), .SNAP(snap2), .SNAP_VLD(vld2), .SNAP_RDY(1'b1),
    .LAT_G(g2), .LAT_GE(ge2), .LAT_D(d2), .BUSY(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!vld && n < 40) begin
      step();
      n++;
    end
    check(tag, {31'd0, vld}, 32'd1);
  endtask

  initial begin
    // reset values
    #1 clr = 1'b1;
    #1;
    check("rst_snap", {24'd0, snap}, 32'h00);
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_g", {31'd0, g}, 32'd0);
    check("rst_ge", {24'd0, ge}, 32'h00);
    check("rst_d", {24'd0, d}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_snap_init1", {24'd0, snap2}, 32'hFF);
    step();
    step();
    clr = 1'b0;

    // INIT=1: synchronizer ones must never be reported
    for (int i = 0; i < 8; i++) begin
      check("init1_no_vld", {31'd0, vld2}, 32'd0);
      check("init1_no_busy", {31'd0, busy2}, 32'd0);
      step();
    end
    check("idle_no_vld", {31'd0, vld}, 32'd0);

    // 1: pulse 0x05 with ready high, latency and clear sequence
    rdy = 1'b1;
    pre = 8'h05;
    step();
    pre = 8'h00;
    check("t1_lat_e1", {31'd0, vld}, 32'd0);
    step();
    check("t1_lat_e2", {31'd0, vld}, 32'd0);
    step();
    check("t1_lat_e3", {31'd0, vld}, 32'd1);
    check("t1_snap", {24'd0, snap}, 32'h05);
    step();
    check("t1_acc_vld", {31'd0, vld}, 32'd0);
    check("t1_g_c1", {31'd0, g}, 32'd1);
    check("t1_ge", {24'd0, ge}, 32'h05);
    check("t1_d", {24'd0, d}, 32'h00);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_latch_cleared", {24'd0, lq}, 32'h00);
    step();
    check("t1_g_c2", {31'd0, g}, 32'd1);
    step();
    check("t1_g_fall", {31'd0, g}, 32'd0);
    check("t1_ge_after_g", {24'd0, ge}, 32'h05);
    step();
    check("t1_ge_fall", {24'd0, ge}, 32'h00);
    check("t1_settle_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_settle_busy2", {31'd0, busy}, 32'd1);
    step();
    check("t1_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_no_second", {31'd0, vld}, 32'd0);
    end

    // 2: consumer stalls for 10 cycles
    rdy = 1'b0;
    pre = 8'h80;
    step();
    pre = 8'h00;
    wait_vld("t2_vld");
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_vld", {31'd0, vld}, 32'd1);
      check("t2_hold_snap", {24'd0, snap}, 32'h80);
      check("t2_hold_g", {31'd0, g}, 32'd0);
      step();
    end
    rdy = 1'b1;
    step();
    check("t2_acc_g", {31'd0, g}, 32'd1);
    check("t2_acc_ge", {24'd0, ge}, 32'h80);
    check("t2_acc_vld", {31'd0, vld}, 32'd0);
    wait_idle("t2_done");
    step();
    step();
    check("t2_no_second", {31'd0, vld}, 32'd0);

    // 3: new flag (bit 3) sets during CLEAR of snapshot 0x01
    pre = 8'h01;
    step();
    pre = 8'h00;
    wait_vld("t3_vld");
    check("t3_snap", {24'd0, snap}, 32'h01);
    step();
    check("t3_ge", {24'd0, ge}, 32'h01);
    check("t3_g", {31'd0, g}, 32'd1);
    pre = 8'h08;
    #1;
    pre = 8'h00;
    check("t3_bit3_kept", {24'd0, lq}, 32'h08);
    wait_idle("t3_idle");
    wait_vld("t3_vld2");
    check("t3_snap2", {24'd0, snap}, 32'h08);
    step();
    wait_idle("t3_done");

    // 4: PRE held on bit 0 throughout CLEAR
    pre = 8'h01;
    wait_vld("t4_vld");
    check("t4_snap", {24'd0, snap}, 32'h01);
    step();
    check("t4_g", {31'd0, g}, 32'd1);
    check("t4_pre_wins", {24'd0, lq}, 32'h01);
    step();
    step();
    check("t4_g_low", {31'd0, g}, 32'd0);
    pre = 8'h00;
    wait_idle("t4_idle");
    wait_vld("t4_rereport");
    check("t4_snap2", {24'd0, snap}, 32'h01);
    step();
    wait_idle("t4_done");
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_no_third", {31'd0, vld}, 32'd0);
    end

    // 5: reset asserted mid-CLEAR while the latch is still set
    pre = 8'h02;
    wait_vld("t5_vld");
    step();
    check("t5_in_clear", {31'd0, g}, 32'd1);
    clr = 1'b1;
    #1;
    check("t5_async_g", {31'd0, g}, 32'd0);
    check("t5_async_ge", {24'd0, ge}, 32'h00);
    check("t5_async_vld", {31'd0, vld}, 32'd0);
    check("t5_async_busy", {31'd0, busy}, 32'd0);
    pre = 8'h00;
    check("t5_latch_kept", {24'd0, lq}, 32'h02);
    step();
    step();
    clr = 1'b0;
    wait_vld("t5_rereport");
    check("t5_snap", {24'd0, snap}, 32'h02);
    step();
    wait_idle("t5_done");
    check("t5_latch_cleared", {24'd0, lq}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
